// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: MSB-first byte serializer with comma idle fill and a comma preamble after reset.
// Latency: a byte accepted at edge E starts on data_out after the first load edge after E (1..WIDTH cycles).
// Backpressure: one-entry holding buffer; ready_out is low while it is full, except on an edge that loads data.
module paralelo_serial_tx #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] COMMA       = 8'hBC,
   parameter int unsigned      SYNC_COMMAS = 4
) (
   input  logic             clk_32f,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             data_out,
   output logic             tx_active,
   output logic             tx_data_flag
);

   localparam int unsigned   BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned   SW        = $clog2(SYNC_COMMAS + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [SW-1:0] SYNC_DONE = SW'(SYNC_COMMAS);
   localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COMMAS - 1);

   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] buf_dat;
   logic             buf_full;
   logic [BW-1:0]    bit_cnt;
   logic [SW-1:0]    sync_cnt;

   logic load_edge;
   logic tx_next;
   logic send_data;
   logic accept;

   // The last bit of every character is on the line: the next edge reloads shift_reg.
   assign load_edge = (bit_cnt == LAST_BIT);
   // The character loaded at this edge is the first one allowed to carry data.
   assign tx_next   = (sync_cnt >= SYNC_LAST);
   assign send_data = load_edge & tx_next & buf_full;

   // Ready depends on state only, so upstream may wait for it before raising valid_in.
   assign ready_out = ~buf_full | (load_edge & tx_next);
   assign accept    = valid_in & ready_out;

   assign data_out  = shift_reg[WIDTH-1];
   assign tx_active = (sync_cnt == SYNC_DONE);

   // Bit counter and shifter: shift on ordinary edges, load a comma or the buffered byte on load edges.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         bit_cnt      <= '0;
         shift_reg    <= COMMA;
         tx_data_flag <= 1'b0;
      end else if (load_edge) begin
         bit_cnt      <= '0;
         shift_reg    <= send_data ? buf_dat : COMMA;
         tx_data_flag <= send_data;
      end else begin
         bit_cnt      <= bit_cnt + BW'(1);
         shift_reg    <= {shift_reg[WIDTH-2:0], 1'b0};
      end
   end

   // Preamble counter: counts loaded characters, saturating once the preamble is complete.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         sync_cnt <= '0;
      end else if (load_edge && (sync_cnt != SYNC_DONE)) begin
         sync_cnt <= sync_cnt + SW'(1);
      end
   end

   // Holding buffer: a new byte overwrites the slot in the same edge the old one moves to the shifter.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         buf_dat  <= '0;
         buf_full <= 1'b0;
      end else if (accept) begin
         buf_dat  <= data_in;
         buf_full <= 1'b1;
      end else if (send_data) begin
         buf_full <= 1'b0;
      end
   end

endmodule
